// File: rtl/clk_div_pkg.sv
// Shared types and sizing helpers for the divided clock-enable bank.
package clk_div_pkg;

    // Lock/reset sequencer states.
    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } state_e;

    // Width of the reset-hold counter; covers RST_HOLD values up to 65536.
    localparam int HOLD_W = 16;

    // Channel index width, never narrower than one bit.
    function automatic int ch_idx_w(input int channels);
        int w;
        w = $clog2(channels);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: div register, phase counter, clock enable and 50% toggle.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_i,
    input  logic             sync_i,
    input  logic             load_i,
    input  logic [DIV_W-1:0] load_div_i,
    output logic             ce_o,
    output logic             clkd_o,
    output logic             apply_ok_o
);

    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             clkd_q, clkd_d;
    logic             tc;

    // Terminal count is derived from registers only; a realign request masks
    // the enable in its own cycle so no pulse lands right before the restart.
    assign tc         = run_i && (div_q != '0) && (cnt_q == div_q - DIV_W'(1));
    assign ce_o       = tc && !sync_i;
    assign clkd_o     = clkd_q && run_i;
    // A pending update may land now: at terminal count, or when the channel is idle.
    assign apply_ok_o = !run_i || (div_q == '0) || tc;

    // Next-state for divider, counter and toggle.
    always_comb begin
        div_d  = load_i ? load_div_i : div_q;
        cnt_d  = cnt_q;
        clkd_d = clkd_q;
        if (!run_i || sync_i) begin
            cnt_d  = '0;
            clkd_d = 1'b0;
        end else begin
            clkd_d = clkd_q ^ tc;
            if (load_i || (div_q == '0) || tc) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q  <= DIV_W'(DEFAULT_DIV);
            cnt_q  <= '0;
            clkd_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            clkd_q <= clkd_d;
        end
    end

endmodule

// File: rtl/clk_div_bank.sv
// Lock filter, reset sequencer, config slot and a bank of divider channels.
// Config port: a transfer happens on any cycle with cfg_valid && cfg_ready;
// cfg_ready depends only on registered state, never on cfg_valid.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int  CHANNELS    = 4,
    parameter int  DIV_W       = 8,
    parameter int  DEFAULT_DIV = 2,
    parameter int  LOCK_CYCLES = 16,
    parameter int  RST_HOLD    = 8,
    localparam int CH_W        = ch_idx_w(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pll_lock,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [DIV_W-1:0]    cfg_div,
    input  logic                sync_req,
    output logic                rst_o,
    output logic                running,
    output logic                cfg_err,
    output logic [CHANNELS-1:0] ce,
    output logic [CHANNELS-1:0] clkd,
    output state_e              state_dbg
);

    localparam int              LOCK_W   = $clog2(LOCK_CYCLES + 1);
    localparam logic [CH_W:0]   CH_LIMIT = (CH_W + 1)'(CHANNELS);

    logic [LOCK_W-1:0]   lock_cnt_q;
    logic                locked;
    state_e              state_q;
    logic [HOLD_W-1:0]   hold_cnt_q;
    logic                rst_q, running_q;
    logic                pend_q, err_q;
    logic [CH_W-1:0]     pend_ch_q;
    logic [DIV_W-1:0]    pend_div_q;
    logic                accept, bad_ch, apply;
    logic [CHANNELS-1:0] load_vec, apply_ok;

    assign locked    = (lock_cnt_q == LOCK_W'(LOCK_CYCLES));
    assign rst_o     = rst_q;
    assign running   = running_q;
    assign state_dbg = state_q;
    assign cfg_ready = !pend_q;
    assign cfg_err   = err_q;
    assign accept    = cfg_valid && !pend_q;
    assign bad_ch    = ({1'b0, cfg_ch} >= CH_LIMIT);
    assign apply     = |load_vec;

    // Lock filter: consecutive locked cycles, saturating, cleared by any drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_cnt_q <= '0;
        end else if (!pll_lock) begin
            lock_cnt_q <= '0;
        end else if (!locked) begin
            lock_cnt_q <= lock_cnt_q + LOCK_W'(1);
        end
    end

    // Sequencer: wait for filtered lock, hold reset RST_HOLD cycles, then run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= WAIT_LOCK;
            hold_cnt_q <= '0;
            rst_q      <= 1'b1;
            running_q  <= 1'b0;
        end else if (!pll_lock) begin
            state_q    <= WAIT_LOCK;
            hold_cnt_q <= '0;
            rst_q      <= 1'b1;
            running_q  <= 1'b0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    if (locked) begin
                        state_q    <= HOLD;
                        hold_cnt_q <= '0;
                    end
                end
                HOLD: begin
                    if (hold_cnt_q == HOLD_W'(RST_HOLD - 1)) begin
                        state_q   <= RUN;
                        rst_q     <= 1'b0;
                        running_q <= 1'b1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
                    end
                end
                RUN: begin
                    state_q <= RUN;
                end
                default: begin
                    state_q    <= WAIT_LOCK;
                    hold_cnt_q <= '0;
                    rst_q      <= 1'b1;
                    running_q  <= 1'b0;
                end
            endcase
        end
    end

    // Single pending update slot; out-of-range channels are reported, not stored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q     <= 1'b0;
            pend_ch_q  <= '0;
            pend_div_q <= '0;
            err_q      <= 1'b0;
        end else begin
            err_q <= accept && bad_ch;
            if (accept && !bad_ch) begin
                pend_q     <= 1'b1;
                pend_ch_q  <= cfg_ch;
                pend_div_q <= cfg_div;
            end else if (apply) begin
                pend_q <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        assign load_vec[i] = pend_q && (pend_ch_q == CH_W'(i)) && apply_ok[i];

        clk_div_chan #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .run_i      (running_q),
            .sync_i     (sync_req),
            .load_i     (load_vec[i]),
            .load_div_i (pend_div_q),
            .ce_o       (ce[i]),
            .clkd_o     (clkd[i]),
            .apply_ok_o (apply_ok[i])
        );
    end

endmodule
